// File: rtl/sram_stream_reader_pkg.sv
// ============================================================================
// Module : sram_stream_reader_pkg
// Brief  : Shared widths and FSM encoding for the SRAM stream reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_stream_reader_pkg;

  // Default widths: address slice of the bank, SRAM output word, length counter
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 13;

  // Reader FSM states with fixed encodings
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : sram_stream_reader_pkg

`default_nettype wire

// File: rtl/sram_stream_reader_if.sv
// ============================================================================
// Module : sram_stream_reader_if
// Brief  : Control, SRAM read port and output stream bundle of the reader.
//          master = reader side, slave = SRAM/controller/sink side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_stream_reader_if
  import sram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

  // Transfer control
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;

  // SRAM read port
  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_rdata;

  // Output stream
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  start, base_addr, stride, len, sram_rdata, m_ready,
    output busy, done, sram_en, sram_we, sram_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, stride, len, sram_rdata, m_ready,
    input  busy, done, sram_en, sram_we, sram_addr, m_valid, m_data, m_last
  );

endinterface : sram_stream_reader_if

`default_nettype wire

// File: rtl/sram_rd_fifo.sv
// ============================================================================
// Module : sram_rd_fifo
// Brief  : 2-entry FIFO holding returned SRAM words plus their last tag.
//          Head is visible combinationally; push and pop may share a cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_rd_fifo #(
  parameter int WIDTH = 9
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              push,
  input  wire  [WIDTH-1:0] push_data,
  input  wire              pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);

  // The issuer's credit check must never let a push land on a full FIFO
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == 2'd2));

endmodule : sram_rd_fifo

`default_nettype wire

// File: rtl/sram_stream_reader.sv
// ============================================================================
// Module : sram_stream_reader
// Brief  : Strided SRAM read initiator. Issues len reads from base by stride,
//          absorbs the 1-cycle read latency and streams words out on a
//          valid/ready port tagged with last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input wire                   clk,
  input wire                   rst,
  sram_stream_reader_if.master bus
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic                  busy_q;
  logic                  done_q;

  logic [DATA_WIDTH:0]   fifo_head;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic [2:0]            occupancy;
  logic                  issue;
  logic                  issue_last;
  logic                  head_last;

  // A word leaves when the head is valid and the sink accepts it
  assign pop = ~fifo_empty & bus.m_ready;

  // Words already owed to the FIFO (stored + in flight), net of this cycle's pop;
  // a new read is only issued while this stays below the FIFO depth
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == ST_RUN) && (occupancy < 3'd2);
  assign issue_last = (remaining == LEN_WIDTH'(1));
  assign head_last  = fifo_head[DATA_WIDTH];

  // Control FSM with address/length counters and the read-latency tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr          <= '0;
      stride_q      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue & issue_last;
      done_q        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            addr      <= bus.base_addr;
            stride_q  <= bus.stride;
            remaining <= bus.len;
            if (bus.len == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr      <= addr + stride_q;
            remaining <= remaining - LEN_WIDTH'(1);
            if (issue_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  sram_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, bus.sram_rdata}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sram_en   = issue;
  assign bus.sram_we   = 1'b0;
  assign bus.sram_addr = addr;
  assign bus.m_valid   = ~fifo_empty;
  assign bus.m_data    = fifo_head[DATA_WIDTH-1:0];
  assign bus.m_last    = head_last;

endmodule : sram_stream_reader

`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
// ============================================================================
// Module : tb_sram_stream_reader
// Brief  : Directed self-checking bench for sram_stream_reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_stream_reader;
  import sram_stream_reader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sram_stream_reader_if bus ();

  sram_stream_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: mem[a] = a[7:0], data one cycle after the enable
  always @(posedge clk) begin
    if (bus.sram_en) bus.sram_rdata <= bus.sram_addr[7:0];
  end

  // Observation logs, sampled mid-cycle
  logic [8:0]  hs_q[$];
  int          hs_cyc[$];
  logic [11:0] addr_q[$];
  int          done_cyc[$];
  int          out_cnt = 0;
  int          credit_err = 0;
  int          stab_err = 0;
  int          we_err = 0;
  bit          prev_stall = 1'b0;
  logic [8:0]  prev_word;

  always @(negedge clk) begin
    bit pop;
    pop = bus.m_valid && bus.m_ready;
    if (rst) begin
      out_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.m_valid || {bus.m_last, bus.m_data} !== prev_word)) stab_err++;
      if (bus.sram_en && (out_cnt - int'(pop)) >= 2) credit_err++;
      if (bus.sram_en) addr_q.push_back(bus.sram_addr);
      if (pop) begin
        hs_q.push_back({bus.m_last, bus.m_data});
        hs_cyc.push_back(cyc);
      end
      out_cnt    = out_cnt + int'(bus.sram_en) - int'(pop);
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_word  = {bus.m_last, bus.m_data};
    end
    if (bus.done) done_cyc.push_back(cyc);
    if (bus.sram_we) we_err++;
  end

  task automatic clear_logs();
    hs_q.delete();
    hs_cyc.delete();
    addr_q.delete();
    done_cyc.delete();
    credit_err = 0;
    stab_err   = 0;
    we_err     = 0;
  endtask

  // Present a one-cycle start; t returns the edge number that samples it
  task automatic launch(input logic [11:0] b, input logic [11:0] s, input logic [12:0] l,
                        output int t);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.stride    = s;
    bus.len       = l;
    t = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Wait for a done pulse within budget, optionally toggling m_ready each cycle
  task automatic run_until_done(input int budget, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (toggle) bus.m_ready = ~bus.m_ready;
      if (done_cyc.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.done, bus.sram_en, bus.m_valid, bus.m_last} !== 5'b0) begin
      $display("FAIL reset_flags: got %b expected 00000", {bus.busy, bus.done, bus.sram_en, bus.m_valid, bus.m_last});
    end else pass_cnt++;
    total_cnt++;
    if (bus.sram_addr !== 12'h000) $display("FAIL reset_addr: got %h expected 000", bus.sram_addr);
    else pass_cnt++;
    total_cnt++;
    if (bus.m_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.m_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.sram_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", bus.sram_we);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int t;
    bit ok;
    logic [8:0] exp;
    clear_logs();
    bus.m_ready = 1'b1;
    launch(12'h010, 12'h001, 13'd4, t);
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", bus.busy);
    else pass_cnt++;
    run_until_done(40, 1'b0, ok);
    total_cnt++;
    if (!ok) $display("FAIL basic_timeout: got no done expected done");
    else pass_cnt++;
    total_cnt++;
    if (hs_q.size() != 4) $display("FAIL basic_count: got %0d expected 4", hs_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
      exp = {(i == 3), 8'h10 + 8'(i)};
      total_cnt++;
      if (hs_q[i] !== exp || hs_cyc[i] != t + 2 + i) begin
        $display("FAIL basic_word[%0d]: got %h@%0d expected %h@%0d", i, hs_q[i], hs_cyc[i], exp, t + 2 + i);
      end else pass_cnt++;
    end
    total_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 6) begin
      $display("FAIL basic_done: got %0d pulses first@%0d expected 1@%0d", done_cyc.size(),
               (done_cyc.size() != 0) ? done_cyc[0] : -1, t + 6);
    end else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int t;
    bit ok;
    logic [8:0] exp;
    clear_logs();
    bus.m_ready = 1'b1;
    launch(12'h010, 12'h001, 13'd4, t);
    run_until_done(60, 1'b1, ok);
    total_cnt++;
    if (!ok || done_cyc.size() != 1) $display("FAIL bp_done: got ok=%0d pulses=%0d expected ok=1 pulses=1", ok, done_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if (hs_q.size() != 4) $display("FAIL bp_count: got %0d expected 4", hs_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
      exp = {(i == 3), 8'h10 + 8'(i)};
      total_cnt++;
      if (hs_q[i] !== exp) $display("FAIL bp_word[%0d]: got %h expected %h", i, hs_q[i], exp);
      else pass_cnt++;
    end
    total_cnt++;
    if (credit_err != 0 || stab_err != 0 || we_err != 0) begin
      $display("FAIL bp_rules: got credit=%0d stable=%0d we=%0d expected all 0", credit_err, stab_err, we_err);
    end else pass_cnt++;
  endtask

  task automatic test_len_zero();
    int t;
    bit ok;
    clear_logs();
    bus.m_ready = 1'b1;
    launch(12'h123, 12'h001, 13'd0, t);
    run_until_done(20, 1'b0, ok);
    total_cnt++;
    if (!ok || done_cyc.size() != 1 || done_cyc[0] != t) begin
      $display("FAIL len0_done: got %0d pulses first@%0d expected 1@%0d", done_cyc.size(),
               (done_cyc.size() != 0) ? done_cyc[0] : -1, t);
    end else pass_cnt++;
    total_cnt++;
    if (addr_q.size() != 0 || hs_q.size() != 0) begin
      $display("FAIL len0_activity: got reads=%0d words=%0d expected 0 0", addr_q.size(), hs_q.size());
    end else pass_cnt++;
  endtask

  task automatic test_wrap();
    int t;
    bit ok;
    logic [11:0] exp_a[3];
    logic [8:0]  exp_w[3];
    exp_a = '{12'hFFE, 12'h001, 12'h004};
    exp_w = '{9'h0FE, 9'h001, 9'h104};
    clear_logs();
    bus.m_ready = 1'b1;
    launch(12'hFFE, 12'h003, 13'd3, t);
    run_until_done(40, 1'b0, ok);
    total_cnt++;
    if (!ok || addr_q.size() != 3 || hs_q.size() != 3) begin
      $display("FAIL wrap_count: got done=%0d reads=%0d words=%0d expected 1 3 3", ok, addr_q.size(), hs_q.size());
    end else pass_cnt++;
    for (int i = 0; i < 3 && i < addr_q.size() && i < hs_q.size(); i++) begin
      total_cnt++;
      if (addr_q[i] !== exp_a[i] || hs_q[i] !== exp_w[i]) begin
        $display("FAIL wrap[%0d]: got addr %h word %h expected addr %h word %h", i, addr_q[i], hs_q[i], exp_a[i], exp_w[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_restart_ignored();
    int t;
    bit ok;
    logic [8:0] exp;
    clear_logs();
    bus.m_ready = 1'b1;
    launch(12'h020, 12'h002, 13'd4, t);
    bus.start     = 1'b1;
    bus.base_addr = 12'h080;
    bus.len       = 13'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    run_until_done(40, 1'b0, ok);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (!ok || done_cyc.size() != 1 || addr_q.size() != 4 || hs_q.size() != 4) begin
      $display("FAIL restart_count: got pulses=%0d reads=%0d words=%0d expected 1 4 4", done_cyc.size(), addr_q.size(), hs_q.size());
    end else pass_cnt++;
    for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
      exp = {(i == 3), 8'h20 + 8'(2 * i)};
      total_cnt++;
      if (hs_q[i] !== exp) $display("FAIL restart_word[%0d]: got %h expected %h", i, hs_q[i], exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    logic [8:0] exp;
    clear_logs();
    bus.m_ready = 1'b0;
    launch(12'h040, 12'h001, 13'd8, t);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.sram_en, bus.m_valid, bus.m_last} !== 5'b0 ||
        bus.sram_addr !== 12'h000 || bus.m_data !== 8'h00) begin
      $display("FAIL rstmid_outputs: got flags %b addr %h data %h expected 00000 000 00",
               {bus.busy, bus.done, bus.sram_en, bus.m_valid, bus.m_last}, bus.sram_addr, bus.m_data);
    end else pass_cnt++;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (done_cyc.size() != 0 || hs_q.size() != 0) begin
      $display("FAIL rstmid_silent: got pulses=%0d words=%0d expected 0 0", done_cyc.size(), hs_q.size());
    end else pass_cnt++;
    clear_logs();
    launch(12'h050, 12'h001, 13'd3, t);
    run_until_done(40, 1'b0, ok);
    total_cnt++;
    if (!ok || done_cyc.size() != 1 || hs_q.size() != 3) begin
      $display("FAIL rstmid_fresh: got done=%0d pulses=%0d words=%0d expected 1 1 3", ok, done_cyc.size(), hs_q.size());
    end else pass_cnt++;
    for (int i = 0; i < 3 && i < hs_q.size(); i++) begin
      exp = {(i == 2), 8'h50 + 8'(i)};
      total_cnt++;
      if (hs_q[i] !== exp) $display("FAIL rstmid_word[%0d]: got %h expected %h", i, hs_q[i], exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.stride    = '0;
    bus.len       = '0;
    bus.m_ready   = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_wrap();
    test_restart_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_sram_stream_reader

`default_nettype wire
